// File: rtl/logic_gate_checker.sv
// logic_gate_checker: valid/ready sink that checks two-input gate results against a golden model.
// LOGIC_GATE_CHK_FIRST_FAIL_EN enables capture of the first failing vector on first_fail.
module logic_gate_checker #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  input  logic             f,
  input  logic             g,
  input  logic             h,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic [5:0]       err_mask,
  output logic [7:0]       first_fail
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] num_lat;
  logic cmp_v;
  logic [7:0] cmp_d;
  logic [5:0] gold, mism;
  logic acc, go, fail;
  assign in_ready = state == RUN;
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  assign pass = done && err_cnt == '0;
  assign acc = in_valid && in_ready;
  assign go = start && (state == IDLE || state == DONE);
  // the compare stage checks the vector accepted one edge earlier
  assign gold = {cmp_d[7] & cmp_d[6], cmp_d[7] | cmp_d[6], ~(cmp_d[7] & cmp_d[6]),
                 ~(cmp_d[7] | cmp_d[6]), cmp_d[7] ^ cmp_d[6], ~cmp_d[7]};
  assign mism = cmp_d[5:0] ^ gold;
  assign fail = cmp_v && |mism;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = go ? (num_vec == '0 ? DONE : RUN) : state;
      RUN:        nxt = acc && CNT_W'(vec_cnt + 1'b1) == num_lat ? DRAIN : RUN;
      default:    nxt = DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      num_lat  <= '0;
      vec_cnt  <= '0;
      err_cnt  <= '0;
      err_mask <= '0;
      cmp_v    <= 1'b0;
      cmp_d    <= '0;
    end else begin
      state <= nxt;
      if (go) begin
        num_lat  <= num_vec;
        vec_cnt  <= '0;
        err_cnt  <= '0;
        err_mask <= '0;
        cmp_v    <= 1'b0;
      end else begin
        cmp_v <= acc;
        if (acc) begin
          cmp_d   <= {a, b, c, d, e, f, g, h};
          vec_cnt <= vec_cnt + 1'b1;
        end
        if (cmp_v) err_mask <= err_mask | mism;
        if (fail && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
      end
    end
  end
`ifdef LOGIC_GATE_CHK_FIRST_FAIL_EN
  // err_cnt==0 marks that no failure has been captured yet this run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) first_fail <= '0;
    else if (go) first_fail <= '0;
    else if (fail && err_cnt == '0) first_fail <= cmp_d;
  end
`else
  assign first_fail = 8'h00;
`endif
endmodule

// File: tb/tb_logic_gate_checker.sv
// tb_logic_gate_checker: directed runs with a result scoreboard checked at each run completion.
module tb_logic_gate_checker;
  localparam int CW = 8;
  localparam int EW = 2;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic a = 0, b = 0, c = 0, d = 0, e = 0, f = 0, g = 0, h = 0;
  logic [CW-1:0] num_vec = '0;
  logic in_ready, busy, done, pass;
  logic [CW-1:0] vec_cnt;
  logic [EW-1:0] err_cnt;
  logic [5:0] err_mask;
  logic [7:0] first_fail;
  int errors = 0, checks = 0;
  typedef struct packed {
    logic [CW-1:0] acc;
    logic [CW-1:0] vc;
    logic [EW-1:0] ec;
    logic [5:0]    m;
    logic          p;
    logic [7:0]    ff;
  } exp_t;
  exp_t q[$];

  logic_gate_checker #(.CNT_W(CW), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .err_mask(err_mask), .first_fail(first_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic logic [5:0] gold(logic x, logic y);
    return {x & y, x | y, ~(x & y), ~(x | y), x ^ y, ~x};
  endfunction

  function automatic exp_t mk(int acc, int vc, int ec, logic [5:0] m, logic p, logic [7:0] ff);
    exp_t x;
    x.acc = CW'(acc);
    x.vc = CW'(vc);
    x.ec = EW'(ec);
    x.m = m;
    x.p = p;
    x.ff = ff;
    return x;
  endfunction

  task automatic send(logic x, logic y, logic [5:0] err, bit hold);
    {a, b} = {x, y};
    {c, d, e, f, g, h} = gold(x, y) ^ err;
    in_valid = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        if (!hold) in_valid = 0;
        return;
      end
    end
    chk("send_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic pulse_start(logic [CW-1:0] n);
    num_vec = n;
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_done;
    for (int i = 0; i < 50; i++) begin
      if (done) return;
      @(negedge clk);
    end
    chk("done_timeout", 0, 1);
  endtask

  // pops one expectation whenever a run completes (done rises, or a zero-length restart from DONE)
  task automatic monitor;
    logic dq, ac, rs;
    exp_t x;
    int n, base;
    dq = 0;
    n = 0;
    base = 0;
    forever begin
      @(posedge clk);
      ac = in_valid && in_ready;
      rs = start && !busy && rst_n;
      @(negedge clk);
      if (ac) n++;
      if (!rst_n) base = n;
      else if (done && (!dq || rs)) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          x = q.pop_front();
          chk("accepts", n - base, 32'(x.acc));
          chk("vec_cnt", vec_cnt, x.vc);
          chk("err_cnt", err_cnt, x.ec);
          chk("err_mask", err_mask, x.m);
          chk("pass", pass, x.p);
`ifdef LOGIC_GATE_CHK_FIRST_FAIL_EN
          chk("first_fail", first_fail, x.ff);
`else
          chk("first_fail_tied", first_fail, 0);
`endif
          base = n;
        end
      end
      dq = done;
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    #12 rst_n = 1;
    @(posedge clk);
    #1 chk("reset_state", {busy, done, pass, in_ready, vec_cnt, err_cnt, err_mask, first_fail}, 0);
    // reset mid-run after two accepts
    pulse_start(4);
    chk("run_ready", {busy, in_ready}, 2'b11);
    send(0, 0, 6'b0, 0);
    send(1, 0, 6'b0, 0);
    chk("mid_vec_cnt", vec_cnt, 2);
    #2 rst_n = 0;
    #1 chk("mid_reset", {busy, done, pass, in_ready, vec_cnt, err_cnt, err_mask, first_fail}, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    // exhaustive correct vectors, in_valid held high
    q.push_back(mk(4, 4, 0, 6'b0, 1, 8'h00));
    pulse_start(4);
    send(0, 0, 6'b0, 1);
    send(1, 0, 6'b0, 1);
    send(0, 1, 6'b0, 1);
    send(1, 1, 6'b0, 1);
    chk("ready_drop", in_ready, 0);
    chk("done_early", done, 0);
    @(posedge clk);
    #1 in_valid = 0;
    chk("done_latency", done, 1);
    chk("pass_direct", pass, 1);
    // g forced high on a=b=1
    q.push_back(mk(4, 4, 1, 6'b000010, 0, {2'b11, gold(1, 1) ^ 6'b000010}));
    pulse_start(4);
    send(0, 0, 6'b0, 1);
    send(1, 0, 6'b0, 1);
    send(0, 1, 6'b0, 1);
    send(1, 1, 6'b000010, 0);
    wait_done();
    // toggled in_valid, start ignored mid-run
    q.push_back(mk(3, 3, 0, 6'b0, 1, 8'h00));
    pulse_start(3);
    send(0, 1, 6'b0, 0);
    pulse_start(7);
    chk("start_ignored", busy, 1);
    send(1, 0, 6'b0, 0);
    @(posedge clk);
    #1;
    send(1, 1, 6'b0, 1);
    chk("ready_after_third", in_ready, 0);
    repeat (3) @(posedge clk);
    #1 in_valid = 0;
    chk("vec_cnt_hold", vec_cnt, 3);
    // every h inverted: saturation of the error counter
    q.push_back(mk(5, 5, 3, 6'b000001, 0, {2'b00, gold(0, 0) ^ 6'b000001}));
    pulse_start(5);
    send(0, 0, 6'b000001, 1);
    send(0, 1, 6'b000001, 1);
    send(1, 0, 6'b000001, 1);
    send(1, 1, 6'b000001, 1);
    send(0, 0, 6'b000001, 0);
    wait_done();
    chk("err_saturated", err_cnt, 3);
    // zero-length run, then restart from DONE
    q.push_back(mk(0, 0, 0, 6'b0, 1, 8'h00));
    pulse_start(0);
    chk("zero_run", {done, busy, pass, vec_cnt, err_cnt, err_mask}, {3'b101, 16'h0});
    q.push_back(mk(1, 1, 0, 6'b0, 1, 8'h00));
    pulse_start(1);
    chk("restart", {done, busy, vec_cnt, err_cnt}, {2'b01, 10'h0});
    send(1, 1, 6'b0, 0);
    wait_done();
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
